wb_read_capture: RTL

WB_READ_CAPTURE -- requirements
Module: wb_read_capture

---
 rtl/wb_read_capture.sv | 138 +++++++++++++
 1 files changed

// File: rtl/wb_read_capture.sv
// Passive Wishbone read monitor: captures one record (address, data, ack/timeout)
// per read strobe and presents it as a single-cycle valid pulse with drop accounting.
module wb_read_capture #(
   parameter logic [15:0] TIMEOUT = 16'd1000
) (
   input  logic       clk_i,
   input  logic       rst_i,
   input  logic       ack_i,
   input  logic [7:0] dat_i,
   input  logic [7:0] adr_o,
   input  logic       stb_o,
   input  logic       we_o,
   input  logic       fifo_full,
   output logic       valid,
   output logic       read_ack,
   output logic [7:0] read_adr,
   output logic [7:0] read_dat,
   output logic [7:0] drop_cnt
);

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_WAIT = 2'd1;
   localparam logic [1:0] S_HOLD = 2'd2;

   localparam logic [15:0] TO_LAST = TIMEOUT - 16'd1;

   logic [1:0]  state_q, state_d;
   logic [15:0] cnt_q, cnt_d;
   logic [7:0]  adr_q, adr_d;
   logic        valid_q, valid_d;
   logic        read_ack_q, read_ack_d;
   logic [7:0]  read_adr_q, read_adr_d;
   logic [7:0]  read_dat_q, read_dat_d;
   logic [7:0]  drop_cnt_q, drop_cnt_d;

   logic        emit;
   logic        emit_ack;
   logic [7:0]  emit_adr;
   logic [7:0]  emit_dat;

   function automatic logic [7:0] sat_inc8(input logic [7:0] v);
      return (v == 8'hFF) ? v : v + 8'd1;
   endfunction

   function automatic logic [15:0] sat_inc16(input logic [15:0] v);
      return (v == 16'hFFFF) ? v : v + 16'd1;
   endfunction

   // Transaction tracking: decides when a record is emitted and what it carries.
   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      adr_d    = adr_q;
      emit     = 1'b0;
      emit_ack = 1'b0;
      emit_adr = adr_q;
      emit_dat = 8'h00;
      case (state_q)
         S_IDLE: begin
            if (stb_o && !we_o) begin
               adr_d = adr_o;
               cnt_d = 16'd0;
               if (ack_i) begin
                  emit     = 1'b1;
                  emit_ack = 1'b1;
                  emit_adr = adr_o;
                  emit_dat = dat_i;
                  state_d  = S_HOLD;
               end else begin
                  state_d  = S_WAIT;
               end
            end
         end
         S_WAIT: begin
            // Ack beats both abort and timeout; a vanished strobe beats timeout.
            if (ack_i) begin
               emit     = 1'b1;
               emit_ack = 1'b1;
               emit_dat = dat_i;
               state_d  = S_HOLD;
            end else if (!stb_o) begin
               state_d  = S_IDLE;
            end else if (cnt_q == TO_LAST) begin
               emit     = 1'b1;
               state_d  = S_HOLD;
            end else begin
               cnt_d    = sat_inc16(cnt_q);
            end
         end
         S_HOLD: begin
            if (!stb_o) begin
               state_d = S_IDLE;
            end
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   // Record outputs: data fields follow every emission, valid only when the FIFO can take it.
   always_comb begin
      valid_d    = emit & ~fifo_full;
      read_ack_d = emit ? emit_ack : read_ack_q;
      read_adr_d = emit ? emit_adr : read_adr_q;
      read_dat_d = emit ? emit_dat : read_dat_q;
      drop_cnt_d = (emit && fifo_full) ? sat_inc8(drop_cnt_q) : drop_cnt_q;
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_q    <= S_IDLE;
         cnt_q      <= 16'd0;
         adr_q      <= 8'h00;
         valid_q    <= 1'b0;
         read_ack_q <= 1'b0;
         read_adr_q <= 8'h00;
         read_dat_q <= 8'h00;
         drop_cnt_q <= 8'h00;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         adr_q      <= adr_d;
         valid_q    <= valid_d;
         read_ack_q <= read_ack_d;
         read_adr_q <= read_adr_d;
         read_dat_q <= read_dat_d;
         drop_cnt_q <= drop_cnt_d;
      end
   end

   assign valid    = valid_q;
   assign read_ack = read_ack_q;
   assign read_adr = read_adr_q;
   assign read_dat = read_dat_q;
   assign drop_cnt = drop_cnt_q;

endmodule
